// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a boot image over a UART line (8N1, LSB first) and writes it
//   word by word into the instruction memory. It holds the CPU stalled
//   until the last word has been written.
//
//   Image format: a 16-bit little-endian word count N, then N 32-bit
//   little-endian words. Word k is written to BASE_ADDR + 4*k.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   rx           in   UART serial input, idle high, asynchronous to clk
//   mem_address  out  byte address of the current/last write
//   mem_data     out  data of the current/last write
//   mem_write    out  one-cycle write strobe
//   cpu_hold     out  high until the whole image has been written
//   done         out  high once the whole image has been written
//   error        out  sticky framing-error flag
//
// Receiver states
//   RX_IDLE  | line idle, waiting for a 1->0 transition
//   RX_START | waiting half a bit to re-check the start bit
//   RX_DATA  | sampling 8 data bits, one per bit period
//   RX_STOP  | waiting one bit period, then checking the stop bit
//
// Loader states
//   LD_LEN_LO | waiting for word count bits 7:0
//   LD_LEN_HI | waiting for word count bits 15:8
//   LD_DATA   | assembling and writing image words
//   LD_DONE   | image complete, further bytes ignored

module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] LD_LEN_LO = 2'd0;
    localparam logic [1:0] LD_LEN_HI = 2'd1;
    localparam logic [1:0] LD_DATA   = 2'd2;
    localparam logic [1:0] LD_DONE   = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizer. The flops reset low so that a line held low
    // through reset never looks like a start bit: a falling edge needs a
    // synchronized high first.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receiver. bit_cnt is a down-counter; a value of 1 is terminal
    // count, so a load of L gives an interval of L cycles.
    // ------------------------------------------------------------------
    logic [1:0]  rx_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        byte_valid;
    logic        bit_tick;

    assign bit_tick = (bit_cnt == 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            rx_shift   <= 8'd0;
            byte_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        bit_cnt  <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (bit_tick) begin
                        if (!rx_sync) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= FULL_BIT;
                            bit_idx  <= 3'd0;
                        end else begin
                            // Too short to be a start bit: drop it silently.
                            rx_state <= RX_IDLE;
                            bit_cnt  <= 16'd0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_cnt  <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin // RX_STOP
                    if (bit_tick) begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                        bit_cnt  <= 16'd0;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader. rx_shift holds the received byte while byte_valid is high
    // and stays put until the next frame's data bits arrive.
    // ------------------------------------------------------------------
    logic [1:0]  ld_state;
    logic [15:0] word_len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] partial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state    <= LD_LEN_LO;
            word_len    <= 16'd0;
            word_idx    <= 16'd0;
            byte_idx    <= 2'd0;
            partial     <= 24'd0;
            mem_address <= BASE_ADDR;
            mem_data    <= 32'd0;
            mem_write   <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (ld_state)
                LD_LEN_LO: begin
                    if (byte_valid) begin
                        word_len[7:0] <= rx_shift;
                        ld_state      <= LD_LEN_HI;
                    end
                end
                LD_LEN_HI: begin
                    if (byte_valid) begin
                        word_len[15:8] <= rx_shift;
                        if ({rx_shift, word_len[7:0]} == 16'd0) begin
                            ld_state <= LD_DONE;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    // word_idx has already been bumped during the write cycle,
                    // so leaving here makes done rise the cycle after the
                    // final strobe.
                    if (mem_write && (word_idx == word_len)) begin
                        ld_state <= LD_DONE;
                    end else if (byte_valid) begin
                        if (byte_idx == 2'd3) begin
                            mem_write   <= 1'b1;
                            mem_data    <= {rx_shift, partial};
                            mem_address <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx    <= word_idx + 16'd1;
                        end else begin
                            // Shift in from the top so byte 0 ends up in 7:0.
                            partial <= {rx_shift, partial[23:8]};
                        end
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: begin // LD_DONE
                end
            endcase
        end
    end

    assign done     = (ld_state == LD_DONE);
    assign cpu_hold = ~done;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_write  (mem_write),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    typedef struct {
        logic [15:0]      len;
        int               nw;
        logic [1:0][31:0] w;
        int               exp_wr;
        logic             exp_done;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_writes = 0;
    logic prev_wr  = 1'b0;
    logic prev_last = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr   = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (prev_last) begin
                check("done_after_last_write", done, 1);
                check("hold_after_last_write", cpu_hold, 0);
            end
            if (mem_write) begin
                n_writes++;
                check("write_one_cycle", prev_wr, 0);
                check("hold_during_write", cpu_hold, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", mem_address, mem_data);
                    prev_last = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", mem_address, mon_e.addr);
                    check("write_data", mem_data, mon_e.data);
                    prev_last = mon_e.last;
                end
            end else begin
                prev_last = 1'b0;
            end
            prev_wr = mem_write;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic last);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values();
        check("rst_mem_address", mem_address, BASE);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        #2;
        check_reset_values();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic check_queue_empty(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d writes still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t vec[4];
    int   wr0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{16'd2, 2, {32'hDEADBEEF, 32'h12345678}, 2, 1'b1};
        vec[1] = '{16'd0, 0, {32'h0, 32'h0},               0, 1'b1};
        vec[2] = '{16'd1, 1, {32'h0, 32'hA55A0FF0},        1, 1'b1};
        vec[3] = '{16'd3, 2, {32'hFFFFFFFF, 32'h00000001}, 2, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);

        // Table-driven images.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            wr0 = n_writes;
            send_byte(vec[t].len[7:0]);
            send_byte(vec[t].len[15:8]);
            for (int k = 0; k < vec[t].nw; k++) begin
                if (k < vec[t].exp_wr)
                    expect_write(BASE + 32'(4 * k), vec[t].w[k], (k == int'(vec[t].len) - 1));
                send_word(vec[t].w[k]);
            end
            repeat (2 * CPB) @(negedge clk);
            check($sformatf("v%0d_write_count", t), n_writes - wr0, vec[t].exp_wr);
            check($sformatf("v%0d_done", t), done, vec[t].exp_done);
            check($sformatf("v%0d_cpu_hold", t), cpu_hold, !vec[t].exp_done);
            check($sformatf("v%0d_error", t), error, 0);
            check_queue_empty($sformatf("v%0d_pending", t));
        end

        // One-cycle low glitch while idle must not start a byte.
        do_reset();
        wr0 = n_writes;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_error", error, 0);
        check("glitch_no_write", n_writes - wr0, 0);
        check("glitch_done", done, 0);
        send_byte(8'h01);
        send_byte(8'h00);
        expect_write(BASE, 32'hCAFEF00D, 1'b1);
        send_word(32'hCAFEF00D);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_then_load_done", done, 1);
        check("glitch_then_load_count", n_writes - wr0, 1);
        check_queue_empty("glitch_pending");

        // Framing error mid-image, then bytes after done are ignored.
        do_reset();
        wr0 = n_writes;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h5A, 1'b0);
        check("frame_error_set", error, 1);
        check("frame_error_no_write", n_writes - wr0, 0);
        expect_write(BASE, 32'h44332211, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (2 * CPB) @(negedge clk);
        check("frame_done", done, 1);
        check("frame_error_sticky", error, 1);
        check("frame_write_count", n_writes - wr0, 1);
        check_queue_empty("frame_pending");
        send_byte(8'h99);
        send_byte(8'h88);
        send_byte(8'h77);
        send_byte(8'h66);
        repeat (2 * CPB) @(negedge clk);
        check("after_done_no_write", n_writes - wr0, 1);
        check("after_done_addr", mem_address, BASE);
        check("after_done_data", mem_data, 32'h44332211);
        check("after_done_done", done, 1);
        check("after_done_error", error, 1);

        // Reset in the middle of a word discards the partial data.
        do_reset();
        wr0 = n_writes;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #2;
        check("midrst_cpu_hold", cpu_hold, 1);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h00);
        expect_write(BASE, 32'hDDCCBBAA, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (2 * CPB) @(negedge clk);
        check("midrst_write_count", n_writes - wr0, 1);
        check("midrst_done_final", done, 1);
        check_queue_empty("midrst_pending");

        // Line held low across reset release must not be taken as a start bit.
        rx  = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        wr0 = n_writes;
        repeat (12 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("lowrst_error", error, 0);
        check("lowrst_no_write", n_writes - wr0, 0);
        send_byte(8'h01);
        send_byte(8'h00);
        expect_write(BASE, 32'h0BADF00D, 1'b1);
        send_word(32'h0BADF00D);
        repeat (2 * CPB) @(negedge clk);
        check("lowrst_load_done", done, 1);
        check("lowrst_load_error", error, 0);
        check_queue_empty("lowrst_pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
